// File: rtl/mlp_pkg.sv
// Shared constants and types for the MLP layer datapath blocks.
package mlp_pkg;

    localparam int unsigned N_REQ_DEF            = 4;
    localparam int unsigned INPUT_WIDTH_DEF      = 32;
    localparam int unsigned FRACTION_IN_BIT_DEF  = 16;
    localparam int unsigned OUTPUT_WIDTH_DEF     = 16;
    localparam int unsigned FRACTION_OUT_BIT_DEF = 8;
    localparam int unsigned BATCH_LEN_DEF        = 4;

    // Occupancy of the single quantized-result register.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } q_state_e;

endpackage

// File: rtl/quant_rr_grant.sv
// Combinational round-robin grant: first asserted request at or after ptr, wrapping.
module quant_rr_grant #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);

    // Scan from ptr upward modulo N_REQ; the first hit wins.
    always_comb begin
        int unsigned pos;
        gnt = '0;
        idx = '0;
        pos = 0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            pos = (32'(ptr) + off) % N_REQ;
            if (req[pos] && (gnt == '0)) begin
                gnt[pos] = 1'b1;
                idx      = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/neuron_quant_arbiter.sv
// Shares one fixed-point quantizer between N_REQ accumulators. Round-robin grant,
// truncating quantizer, single output register tagged with requester index, and a
// batch counter that pulses batch_done every BATCH_LEN output handshakes.
// Optional feature: define QUANT_SAT_EN to clamp out-of-range results (out_sat=1).
module neuron_quant_arbiter
    import mlp_pkg::*;
#(
    parameter int unsigned N_REQ            = N_REQ_DEF,
    parameter int unsigned INPUT_WIDTH      = INPUT_WIDTH_DEF,
    parameter int unsigned FRACTION_IN_BIT  = FRACTION_IN_BIT_DEF,
    parameter int unsigned OUTPUT_WIDTH     = OUTPUT_WIDTH_DEF,
    parameter int unsigned FRACTION_OUT_BIT = FRACTION_OUT_BIT_DEF,
    parameter int unsigned BATCH_LEN        = BATCH_LEN_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ*INPUT_WIDTH-1:0] req_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUTPUT_WIDTH-1:0]      out_data,
    output logic [$clog2(N_REQ)-1:0]     out_id,
    output logic                         out_sat,
    output logic                         batch_done
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = (BATCH_LEN > 1) ? $clog2(BATCH_LEN) : 1;
    // Output window inside the accumulator word.
    localparam int unsigned LSB   = FRACTION_IN_BIT - FRACTION_OUT_BIT;
    localparam int unsigned MSB   = LSB + OUTPUT_WIDTH - 1;

    q_state_e                state_q;
    logic [OUTPUT_WIDTH-1:0] data_q;
    logic [IDX_W-1:0]        id_q;
    logic                    sat_q;
    logic [IDX_W-1:0]        ptr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    done_q;

    logic [N_REQ-1:0]        gnt;
    logic [IDX_W-1:0]        gnt_idx;
    logic [IDX_W-1:0]        ptr_nxt;
    logic                    load;
    logic                    hs;
    logic                    xfer;
    logic [INPUT_WIDTH-1:0]  sel_data;
    logic [OUTPUT_WIDTH-1:0] q_data;
    logic                    q_sat;
    logic                    unused_sel;

    quant_rr_grant #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_grant (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    // Handshake decode; ready is suppressed during reset so nothing is accepted then.
    always_comb begin
        load      = (state_q == EMPTY) || out_ready;
        req_ready = (load && !rst) ? gnt : '0;
        xfer      = |(req_valid & req_ready);
        hs        = (state_q == FULL) && out_ready;
        ptr_nxt   = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    assign sel_data   = req_data[gnt_idx*INPUT_WIDTH +: INPUT_WIDTH];
    // Fraction bits below the window are dropped by design.
    assign unused_sel = ^sel_data;

    // Truncating quantizer, with optional clamp when the dropped high bits disagree
    // with the output sign bit.
    always_comb begin
        q_data = sel_data[MSB:LSB];
        q_sat  = 1'b0;
`ifdef QUANT_SAT_EN
        for (int b = MSB + 1; b < INPUT_WIDTH; b++) begin
            if (sel_data[b] != sel_data[MSB]) begin
                q_sat = 1'b1;
            end
        end
        if (q_sat) begin
            q_data = sel_data[INPUT_WIDTH-1] ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}}
                                             : {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
        end
`endif
    end

    // Output register and arbitration pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            sat_q   <= 1'b0;
            ptr_q   <= '0;
        end else if (xfer) begin
            state_q <= FULL;
            data_q  <= q_data;
            id_q    <= gnt_idx;
            sat_q   <= q_sat;
            ptr_q   <= ptr_nxt;
        end else if (hs) begin
            state_q <= EMPTY;
        end
    end

    // Batch counter; batch_done is a registered one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (hs) begin
                if (cnt_q == CNT_W'(BATCH_LEN - 1)) begin
                    cnt_q  <= '0;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign out_valid  = (state_q == FULL);
    assign out_data   = data_q;
    assign out_id     = id_q;
    assign out_sat    = sat_q;
    assign batch_done = done_q;

endmodule

// File: doc/neuron_quant_arbiter.md
# neuron_quant_arbiter

Shares one fixed-point quantizer between `N_REQ` neuron accumulators in an MLP layer. Each requester offers a wide accumulator result over a valid/ready handshake. A round-robin arbiter grants one requester per cycle, and its value is narrowed to the activation format. The quantized result is held in a single output register tagged with the requester index. The block also counts emitted results and pulses `batch_done` when a full layer's worth has been delivered.

## Interface
- `N_REQ`, 4: number of requesters (≥2).
- `INPUT_WIDTH`, 32: accumulator width per requester, two's complement.
- `FRACTION_IN_BIT`, 16: fraction bits in the input.
- `OUTPUT_WIDTH`, 16: quantized width, two's complement.
- `FRACTION_OUT_BIT`, 8: fraction bits in the output (≤ `FRACTION_IN_BIT`).
- `BATCH_LEN`, 4: results per layer before `batch_done` (≥1).
- `clk`  in  1  sole clock; all state is updated on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  N_REQ  per-requester data valid.
- `req_ready`  out  N_REQ  per-requester accept; one-hot or zero.
- `req_data`  in  N_REQ*INPUT_WIDTH  packed accumulators; requester i occupies bits [i*INPUT_WIDTH +: INPUT_WIDTH].
- `out_valid`  out  1  quantized result held.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  OUTPUT_WIDTH  quantized value.
- `out_id`  out  $clog2(N_REQ)  index of the requester that produced `out_data`.
- `out_sat`  out  1  result was clamped; constant 0 without saturation.
- `batch_done`  out  1  one-cycle pulse on the `BATCH_LEN`-th output handshake.

## Operation
- **States:**
  - EMPTY: output register free.
  - FULL: `out_valid`=1, waiting for `out_ready`.
- **Load enable:** `load = !out_valid || out_ready`.
  - `req_ready[i]` is high only for the granted requester, and only while `load` is high.
  - A transfer occurs when `req_valid[i] && req_ready[i]`.
  - `req_ready` is combinational from `req_valid`, pointer, `out_valid` and `out_ready`.
- **Arbitration:**
  - Round-robin from pointer `ptr`: grant the first i with `req_valid[i]`, scanning ptr, ptr+1, …, wrapping modulo N_REQ.
  - After a transfer from i, `ptr = (i+1) mod N_REQ`.
  - Without a transfer, `ptr` holds.
- **State transitions:**
  - Transfer: register loads the quantized data, `out_id`=i and `out_sat`, and the state becomes FULL.
  - Output handshake with no new transfer: FULL→EMPTY.
  - Handshake and transfer in the same cycle: stay FULL with the new data (full throughput).
- **Quantization (truncate):**
  - `out_data` = input bits [FRACTION_IN_BIT+OUTPUT_WIDTH-FRACTION_OUT_BIT-1 : FRACTION_IN_BIT-FRACTION_OUT_BIT].
  - Low fraction bits are dropped without rounding.
  - Integer bits above the output range are discarded.
- **Batch counter:**
  - `cnt` increments on each output handshake.
  - When the handshake occurs with `cnt==BATCH_LEN-1`, `batch_done` pulses and `cnt` returns to 0.
- **Invalid requesters:** a requester with `req_valid` low is never granted, regardless of `ptr`.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0, `out_id`=0, `out_sat`=0, `batch_done`=0, `ptr`=0, `cnt`=0, and `req_ready`=0 during the reset cycle.
- **Latency:** a transfer in cycle T produces `out_valid`=1 with the data from cycle T+1.
- **Throughput:** one result per cycle while `out_ready` is held high.
- **Backpressure:** while FULL and `out_ready`=0, all `req_ready`=0 and the output holds stable.
- **Reset mid-operation:** a held result is discarded and `cnt` is cleared. A requester granted in the reset cycle is not accepted, because `req_ready`=0.
- **`batch_done` timing:** registered; asserted the cycle after the qualifying handshake, for exactly one cycle.

## Configuration
- **`QUANT_SAT_EN` defined:**
  - If the discarded upper input bits are not all equal to the output sign bit, `out_data` clamps to the signed maximum (0x7FFF at default widths) when the input is non-negative, or the signed minimum (0x8000) when negative.
  - `out_sat`=1 is registered with the data.
- **`QUANT_SAT_EN` undefined:** plain truncation and `out_sat` tied 0.

## Structure
- **Shared package `mlp_pkg`:**
  - Default width and fraction constants.
  - The `q_state_e` enum {EMPTY, FULL}.
- **Sub-module `quant_rr_grant`:**
  - Inputs: `req` vector and `ptr`.
  - Outputs: one-hot grant and the encoded index.
  - Purely combinational.
- **Datapath:** quantization (truncate, plus saturation under the macro) is done inline on the granted input; the registers live in this block.

## Test plan
All scenarios use default parameters.
- Reset, then req_valid=4'b0001, req_data[0]=0x0001_8000 (1.5), out_ready=1 -> T+1: out_valid=1, out_data=0x0180, out_id=0, out_sat=0.
- All four requesters valid every cycle, out_ready=1 -> grants in order 0,1,2,3,0; `batch_done` pulses exactly once, one cycle after the 4th handshake.
- Input 0x0100_0000 (256.0) -> out_data=0x0000 without the macro; with `QUANT_SAT_EN`, out_data=0x7FFF and out_sat=1. Input 0xFF00_0000 (-256.0) -> 0x8000 with out_sat=1 under the macro; 0xFFFE_8000 (-1.5) -> 0xFE80, out_sat=0.
- out_ready=0 for 5 cycles with a result held -> out_data and out_id stable and all req_ready=0; releasing out_ready accepts the next requester in the same cycle.
- Only requester 2 valid, with ptr=3 after a prior grant to 2 -> the scan wraps and grants 2, then ptr=3.
- Assert rst while FULL with cnt=2 -> next cycle out_valid=0 and cnt=0; four further handshakes are required before `batch_done`.
